// File: rtl/usb_int_pkg.sv
// Shared constants for the USB INT# interrupt controller: register map, bit indices, FSM encoding.
// No latency or backpressure of its own; imported by the controller and its debounce stage.
package usb_int_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int STATUS_DEB    = 0;
  localparam int STATUS_SYNC   = 1;
  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_EDGE_SEL = 1;
  localparam int EDGE_PENDING  = 0;
  localparam int EDGE_OVERFLOW = 1;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_t;

  typedef struct packed {
    logic edge_sel;
    logic irq_en;
  } ctrl_t;

endpackage

// File: rtl/usb_int_debounce.sv
// Synchroniser plus debounce FSM for INT#; a clean step is accepted SYNC_STAGES+DEBOUNCE_CYCLES cycles
// after the first sampling edge, with a one-cycle edge_pulse alongside the new level. No backpressure.
module usb_int_debounce
  import usb_int_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_port,
  output logic deb_level,
  output logic sync_level,
  output logic edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  deb_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   deb_nxt;
  logic                   pulse_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      deb_level  <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      deb_level  <= deb_nxt;
      edge_pulse <= pulse_nxt;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = deb_level;
    pulse_nxt = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync_level != deb_level) begin
          state_nxt = ST_CHECK;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (sync_level == deb_level) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          deb_nxt   = sync_level;
          pulse_nxt = 1'b1;
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/usb_int_ctrl.sv
// USB INT# interrupt controller: debounced edge capture into sticky pending/overflow, maskable level irq.
// Avalon readLatency 1, zero wait states, never stalls; irq follows pending by one cycle.
module usb_int_ctrl
  import usb_int_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic        deb_level;
  logic        sync_level;
  logic        edge_pulse;
  ctrl_t       ctrl;
  logic        pending;
  logic        overflow;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_edge;
  logic        qual_edge;
  logic        clr_pend;
  logic        clr_ovf;
  logic [31:0] rd_nxt;
  logic        unused_wdata;

  usb_int_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .deb_level  (deb_level),
    .sync_level (sync_level),
    .edge_pulse (edge_pulse)
  );

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_edge   = wr_en && (address == ADDR_EDGE);
  assign clr_pend  = wr_edge & writedata[EDGE_PENDING];
  assign clr_ovf   = wr_edge & writedata[EDGE_OVERFLOW];
  // deb_level already holds the new level while edge_pulse is high.
  assign qual_edge = edge_pulse && (deb_level == ctrl.edge_sel);
  assign unused_wdata = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.irq_en   <= writedata[CTRL_IRQ_EN];
      ctrl.edge_sel <= writedata[CTRL_EDGE_SEL];
    end
  end

  // Capture beats a same-cycle W1C on the bit it would set or keep set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (qual_edge) begin
        pending <= 1'b1;
      end else if (clr_pend) begin
        pending <= 1'b0;
      end
      if (qual_edge && pending) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_STATUS: begin
        rd_nxt[STATUS_DEB]  = deb_level;
        rd_nxt[STATUS_SYNC] = sync_level;
      end
      ADDR_CTRL: begin
        rd_nxt[CTRL_IRQ_EN]   = ctrl.irq_en;
        rd_nxt[CTRL_EDGE_SEL] = ctrl.edge_sel;
      end
      ADDR_EDGE: begin
        rd_nxt[EDGE_PENDING]  = pending;
        rd_nxt[EDGE_OVERFLOW] = overflow;
      end
      ADDR_RSVD: rd_nxt = '0;
      default:   rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_nxt;
      irq      <= ctrl.irq_en & pending;
    end
  end

endmodule
